// File: rtl/hazard_ctrl_if.sv
// Pipeline-side bundle between the F/D/E/M/W datapath and the hazard controller.
// The pipeline (master) supplies register addresses and status; the controller (slave) returns holds, clears and selects.
interface hazard_ctrl_if #(
  parameter int CNT_W = 32
);
  logic [4:0]       ad1d, ad2d;
  logic [4:0]       ad1e, ad2e, rde;
  logic             reade;
  logic             pcSrce;
  logic             mcReqe;
  logic             mcDone;
  logic [4:0]       rdm, rdw;
  logic             regWrtm, regWrtw;
  logic             stallf, stalld, stalle;
  logic             flushd, flushe, flushm;
  logic [1:0]       fwdAe, fwdBe;
  logic             mcStart;
  logic             mcBusy;
  logic             mcErr;
  logic [CNT_W-1:0] stallCnt;

  modport master (
    output ad1d, ad2d, ad1e, ad2e, rde, reade, pcSrce, mcReqe, mcDone,
           rdm, rdw, regWrtm, regWrtw,
    input  stallf, stalld, stalle, flushd, flushe, flushm, fwdAe, fwdBe,
           mcStart, mcBusy, mcErr, stallCnt
  );

  modport slave (
    input  ad1d, ad2d, ad1e, ad2e, rde, reade, pcSrce, mcReqe, mcDone,
           rdm, rdw, regWrtm, regWrtw,
    output stallf, stalld, stalle, flushd, flushe, flushm, fwdAe, fwdBe,
           mcStart, mcBusy, mcErr, stallCnt
  );
endinterface

// File: rtl/hazard_ctrl.sv
// Hazard and sequencing controller for the 5-stage in-order core: forwarding, load-use and
// branch flushes, multi-cycle unit start/done handshake with timeout, and a stall-cycle counter.
module hazard_ctrl #(
  parameter int MC_TIMEOUT = 64,
  parameter int CNT_W      = 32
) (
  input logic         clk,
  input logic         rstn,
  hazard_ctrl_if.slave hz
);
  localparam int TW = (MC_TIMEOUT > 2) ? $clog2(MC_TIMEOUT) : 1;

  typedef enum logic {ST_RUN, ST_WAIT} state_t;

  state_t           state, state_nx;
  logic [TW-1:0]    timer, timer_nx;
  logic             tmo, lu, mcs, stall;
  logic             mc_start, err_set;
  logic             mc_err;
  logic [CNT_W-1:0] stall_cnt;

  // Memory stage holds the younger result, so it wins over writeback.
  function automatic logic [1:0] fwd_sel(input logic [4:0] src, input logic [4:0] rdm,
                                         input logic [4:0] rdw, input logic regWrtm,
                                         input logic regWrtw);
    if (regWrtm && rdm != 5'd0 && rdm == src)      return 2'b10;
    else if (regWrtw && rdw != 5'd0 && rdw == src) return 2'b01;
    else                                           return 2'b00;
  endfunction

  assign hz.fwdAe = fwd_sel(hz.ad1e, hz.rdm, hz.rdw, hz.regWrtm, hz.regWrtw);
  assign hz.fwdBe = fwd_sel(hz.ad2e, hz.rdm, hz.rdw, hz.regWrtm, hz.regWrtw);

  assign tmo   = (timer == TW'(MC_TIMEOUT - 1));
  assign lu    = hz.reade && (hz.rde != 5'd0) && (hz.rde == hz.ad1d || hz.rde == hz.ad2d);
  assign mcs   = hz.mcReqe && !(state == ST_WAIT && (hz.mcDone || tmo));
  assign stall = lu || mcs;

  // A frozen E stage already keeps the load in place, so no bubble is injected under mcs.
  assign hz.stallf = stall;
  assign hz.stalld = stall;
  assign hz.stalle = mcs;
  assign hz.flushd = hz.pcSrce;
  assign hz.flushe = hz.pcSrce || (lu && !mcs);
  assign hz.flushm = mcs;

  // NOTE: every signal driven here gets a default first, so no path can infer a latch.
  always_comb begin
    state_nx = state;
    timer_nx = timer;
    mc_start = 1'b0;
    err_set  = 1'b0;
    case (state)
      ST_RUN: begin
        if (hz.mcReqe && rstn) begin
          mc_start = 1'b1;
          state_nx = ST_WAIT;
          timer_nx = '0;
        end
      end
      ST_WAIT: begin
        timer_nx = timer + TW'(1);
        if (hz.mcDone) begin
          state_nx = ST_RUN;
        end else if (tmo) begin
          err_set  = 1'b1;
          state_nx = ST_RUN;
        end
      end
      default: state_nx = ST_RUN;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state     <= ST_RUN;
      timer     <= '0;
      mc_err    <= 1'b0;
      stall_cnt <= '0;
    end else begin
      state <= state_nx;
      timer <= timer_nx;
      if (err_set) mc_err <= 1'b1;
      if (stall && stall_cnt != '1) stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

  assign hz.mcStart  = mc_start;
  assign hz.mcBusy   = (state == ST_WAIT);
  assign hz.mcErr    = mc_err;
  assign hz.stallCnt = stall_cnt;
endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: two instances (long and short timeout / wide and narrow counter) share
// one stimulus stream and are compared every cycle against a cycle-level behavioural model.
module tb_hazard_ctrl;
  localparam int TA = 16, CA = 8;
  localparam int TB = 4,  CB = 3;

  logic clk = 1'b0;
  logic rstn;
  always #5 clk = ~clk;

  logic [4:0] ad1d, ad2d, ad1e, ad2e, rde, rdm, rdw;
  logic       reade, pcSrce, mcReqe, mcDone, regWrtm, regWrtw;

  hazard_ctrl_if #(.CNT_W(CA)) ia ();
  hazard_ctrl_if #(.CNT_W(CB)) ib ();

  hazard_ctrl #(.MC_TIMEOUT(TA), .CNT_W(CA)) dut_a (.clk(clk), .rstn(rstn), .hz(ia.slave));
  hazard_ctrl #(.MC_TIMEOUT(TB), .CNT_W(CB)) dut_b (.clk(clk), .rstn(rstn), .hz(ib.slave));

  assign ia.ad1d = ad1d;     assign ib.ad1d = ad1d;
  assign ia.ad2d = ad2d;     assign ib.ad2d = ad2d;
  assign ia.ad1e = ad1e;     assign ib.ad1e = ad1e;
  assign ia.ad2e = ad2e;     assign ib.ad2e = ad2e;
  assign ia.rde = rde;       assign ib.rde = rde;
  assign ia.reade = reade;   assign ib.reade = reade;
  assign ia.pcSrce = pcSrce; assign ib.pcSrce = pcSrce;
  assign ia.mcReqe = mcReqe; assign ib.mcReqe = mcReqe;
  assign ia.mcDone = mcDone; assign ib.mcDone = mcDone;
  assign ia.rdm = rdm;       assign ib.rdm = rdm;
  assign ia.rdw = rdw;       assign ib.rdw = rdw;
  assign ia.regWrtm = regWrtm; assign ib.regWrtm = regWrtm;
  assign ia.regWrtw = regWrtw; assign ib.regWrtw = regWrtw;

  int checks = 0;
  int errors = 0;

  // Model state per instance: in-flight flag, cycles spent waiting, sticky error, stall count.
  bit busy [2];
  int wcnt [2];
  bit err  [2];
  int cnt  [2];
  int tmo_c [2] = '{TA, TB};
  int max_c [2] = '{(1 << CA) - 1, (1 << CB) - 1};

  typedef struct packed {
    logic       stallf, stalld, stalle, flushd, flushe, flushm;
    logic [1:0] fa, fb;
    logic       start, mbusy, merr;
    logic [7:0] scnt;
  } obs_t;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [1:0] exp_fwd(input logic [4:0] src);
    if (regWrtm && rdm != 0 && rdm == src) return 2'b10;
    if (regWrtw && rdw != 0 && rdw == src) return 2'b01;
    return 2'b00;
  endfunction

  function automatic bit exp_lu();
    return reade && rde != 0 && (rde == ad1d || rde == ad2d);
  endfunction

  function automatic bit exp_mcs(input int k);
    return mcReqe && !(busy[k] && (mcDone || wcnt[k] == tmo_c[k] - 1));
  endfunction

  function automatic obs_t sample(input int k);
    obs_t o;
    if (k == 0)
      o = '{ia.stallf, ia.stalld, ia.stalle, ia.flushd, ia.flushe, ia.flushm,
            ia.fwdAe, ia.fwdBe, ia.mcStart, ia.mcBusy, ia.mcErr, ia.stallCnt};
    else
      o = '{ib.stallf, ib.stalld, ib.stalle, ib.flushd, ib.flushe, ib.flushm,
            ib.fwdAe, ib.fwdBe, ib.mcStart, ib.mcBusy, ib.mcErr, {5'b0, ib.stallCnt}};
    return o;
  endfunction

  task automatic check_all();
    for (int k = 0; k < 2; k++) begin
      obs_t  o;
      bit    lu, mcs, st;
      string p;
      o   = sample(k);
      p   = (k == 0) ? "a_" : "b_";
      lu  = exp_lu();
      mcs = exp_mcs(k);
      st  = lu || mcs;
      check({p, "stallf"}, o.stallf, st);
      check({p, "stalld"}, o.stalld, st);
      check({p, "stalle"}, o.stalle, mcs);
      check({p, "flushd"}, o.flushd, pcSrce);
      check({p, "flushe"}, o.flushe, pcSrce || (lu && !mcs));
      check({p, "flushm"}, o.flushm, mcs);
      check({p, "fwdAe"}, o.fa, exp_fwd(ad1e));
      check({p, "fwdBe"}, o.fb, exp_fwd(ad2e));
      check({p, "mcStart"}, o.start, rstn && !busy[k] && mcReqe);
      check({p, "mcBusy"}, o.mbusy, busy[k]);
      check({p, "mcErr"}, o.merr, err[k]);
      check({p, "stallCnt"}, o.scnt, cnt[k]);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      busy[k] = 0; wcnt[k] = 0; err[k] = 0; cnt[k] = 0;
    end
  endtask

  task automatic model_step();
    bit lu;
    if (!rstn) begin
      model_reset();
      return;
    end
    lu = exp_lu();
    for (int k = 0; k < 2; k++) begin
      if ((lu || exp_mcs(k)) && cnt[k] < max_c[k]) cnt[k]++;
      if (!busy[k]) begin
        if (mcReqe) begin busy[k] = 1; wcnt[k] = 0; end
      end else if (mcDone) begin
        busy[k] = 0;
      end else if (wcnt[k] == tmo_c[k] - 1) begin
        err[k] = 1; busy[k] = 0;
      end else begin
        wcnt[k]++;
      end
    end
  endtask

  // Compare mid-cycle, then advance the model on the edge; inputs change 1ns after the edge.
  task automatic cycle();
    @(negedge clk);
    check_all();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic clear_inputs();
    {ad1d, ad2d, ad1e, ad2e, rde, rdm, rdw} = '0;
    {reade, pcSrce, mcReqe, mcDone, regWrtm, regWrtw} = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    clear_inputs();
    rstn = 1'b0;
    model_reset();
    #2;
    check("reset_busy", ia.mcBusy, 1'b0);
    check("reset_cnt", ia.stallCnt, 8'd0);
    check("reset_stallf", ia.stallf, 1'b0);
    cycle(); cycle();
    rstn = 1'b1;
    cycle();

    // Forwarding priority and x0 exclusion
    regWrtm = 1; rdm = 5; regWrtw = 1; rdw = 5; ad1e = 5; ad2e = 0;
    #1 check("fwd_mem_A", ia.fwdAe, 2'b10);
    check("fwd_mem_B", ia.fwdBe, 2'b00);
    cycle();
    regWrtm = 0;
    #1 check("fwd_wb_A", ia.fwdAe, 2'b01);
    cycle();
    regWrtm = 1; rdm = 0; rdw = 0; ad1e = 0;
    #1 check("fwd_x0_A", ia.fwdAe, 2'b00);
    cycle();
    clear_inputs();

    // Load-use: one bubble, counted once
    reade = 1; rde = 7; ad2d = 7;
    #1 check("lu_stallf", ia.stallf, 1'b1);
    check("lu_stalle", ia.stalle, 1'b0);
    check("lu_flushe", ia.flushe, 1'b1);
    cycle();
    check("lu_cnt", ia.stallCnt, 8'd1);
    rde = 0;
    #1 check("lu_x0_stallf", ia.stallf, 1'b0);
    cycle();
    clear_inputs();

    // Branch alone and with a concurrent load-use
    pcSrce = 1;
    #1 check("br_flushd", ia.flushd, 1'b1);
    check("br_flushe", ia.flushe, 1'b1);
    check("br_stallf", ia.stallf, 1'b0);
    cycle();
    reade = 1; rde = 7; ad1d = 7;
    #1 check("brlu_flushd", ia.flushd, 1'b1);
    check("brlu_stalld", ia.stalld, 1'b1);
    cycle();
    clear_inputs();

    // Multi-cycle op: start, five waiting cycles, done releases; then back-to-back restart
    mcReqe = 1;
    for (int i = 0; i < 7; i++) begin
      mcDone = (i == 6);
      #1 check("mc_start", ia.mcStart, i == 0);
      check("mc_stall", ia.stallf, i < 6);
      check("mc_flushm", ia.flushm, i < 6);
      check("mc_busy", ia.mcBusy, i >= 1);
      cycle();
    end
    mcDone = 0;
    #1 check("mc_b2b_start", ia.mcStart, 1'b1);
    check("mc_b2b_busy", ia.mcBusy, 1'b0);
    cycle();
    mcReqe = 0; mcDone = 1;
    cycle();
    clear_inputs();

    // Timeout on the short-timeout instance
    rstn = 0; model_reset();
    cycle();
    rstn = 1;
    mcReqe = 1;
    for (int i = 0; i < 5; i++) begin
      #1 check("tmo_stall", ib.stallf, i < 4);
      check("tmo_busy", ib.mcBusy, i >= 1);
      check("tmo_err_low", ib.mcErr, 1'b0);
      cycle();
    end
    check("tmo_err_set", ib.mcErr, 1'b1);
    mcReqe = 0;
    repeat (20) cycle();
    check("tmo_err_sticky", ib.mcErr, 1'b1);

    // Asynchronous reset in the middle of a wait
    mcReqe = 1;
    cycle(); cycle();
    rstn = 0;
    #1 model_reset();
    check("arst_busy_a", ia.mcBusy, 1'b0);
    check("arst_cnt_a", ia.stallCnt, 8'd0);
    check("arst_err_b", ib.mcErr, 1'b0);
    check("arst_busy_b", ib.mcBusy, 1'b0);
    check("arst_nostart", ia.mcStart, 1'b0);
    cycle();
    rstn = 1;
    #1 check("arst_fresh_start", ia.mcStart, 1'b1);
    cycle();
    check("arst_busy_after", ia.mcBusy, 1'b1);
    mcReqe = 0; mcDone = 1;
    cycle();
    clear_inputs();

    // Narrow counter saturation
    reade = 1; rde = 3; ad1d = 3;
    repeat (10) cycle();
    check("sat_cnt_b", ib.stallCnt, 3'd7);
    clear_inputs();

    // Randomized traffic, small register range to provoke matches
    for (int n = 0; n < 400; n++) begin
      ad1d = 5'($urandom_range(0, 3)); ad2d = 5'($urandom_range(0, 3));
      ad1e = 5'($urandom_range(0, 3)); ad2e = 5'($urandom_range(0, 3));
      rde  = 5'($urandom_range(0, 3)); rdm  = 5'($urandom_range(0, 3));
      rdw  = 5'($urandom_range(0, 3));
      reade   = ($urandom_range(0, 3) == 0);
      pcSrce  = ($urandom_range(0, 5) == 0);
      mcReqe  = ($urandom_range(0, 2) == 0);
      mcDone  = ($urandom_range(0, 4) == 0);
      regWrtm = $urandom_range(0, 1) == 1;
      regWrtw = $urandom_range(0, 1) == 1;
      if (n == 200) begin
        rstn = 0;
        #1 model_reset();
        check("rnd_arst_cnt", ia.stallCnt, 8'd0);
        cycle();
        rstn = 1;
      end else begin
        cycle();
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
